parallel_sys7: RTL and testbench
================================

Name: parallel_sys7

Overview:
Top-level BER/FER measurement array for the FEC emulation flow. It instantiates N_CORES independent sys7 link-simulation cores (transmit, noise injection, decode, error counting) and broadcasts one shared noise-probability table and configuration to all of them. Each core gets a distinct noise seed. The block sums the per-core 64-bit statistics into five global counters that software reads.

Parameters:
N_CORES, 10, number of parallel sys7 cores (1..32).
SEED_BASE, 32'h0000_0001, PRNG seed of core 0; core i receives SEED_BASE + i*32'h9E37_79B9.
TABLE_DEPTH, 64, number of probability-table entries (fixed by the core).

Ports:
clk  in  1  system clock, all logic on rising edge.
rstn  in  1  synchronous active-low reset.
en  in  1  run enable; low freezes all cores and counters.
probability_in  in  64  table write data (cumulative noise probability word).
probability_idx  in  32  table write address; 0..63 writes, any other value is idle (32'hFFFF_FFFF by convention).
n_interleave  in  4  FEC interleave depth broadcast to cores.
total_bits  out  64  sum of core bit counters.
total_bit_errors_pre  out  64  sum of pre-FEC bit errors.
total_bit_errors_post  out  64  sum of post-FEC bit errors.
total_frames  out  64  sum of processed frames.
total_frame_errors  out  64  sum of uncorrectable frames.

Behaviour:
- Reset: rstn sampled low on a clk edge clears all output registers, the adder pipeline and the broadcast registers to 0. rstn is forwarded unregistered to every core. Table contents are NOT cleared by reset, so the table can be loaded while rstn is low.
- Table load: probability_idx and probability_in are registered once, then broadcast to every core's table port. A write lands in all cores 1 cycle after the input edge. Writes are accepted regardless of en and rstn. idx >= 64 causes no write. Back-to-back writes are allowed, one per cycle. The last write to an index wins.
- n_interleave: registered once and broadcast. A value of 0 is clamped to 1. Changing it while running gives undefined statistics; software changes it only under reset.
- en: forwarded unregistered to all cores. en=0 stalls the cores. The adder pipeline keeps running, so the outputs settle to the frozen sums L cycles later.
- Aggregation: per statistic, a registered binary adder tree over N_CORES inputs. Latency L = ceil(log2(N_CORES)) + 1 cycles from a core counter change to the output; L = 5 for N_CORES = 10. Unused leaves in a non-power-of-two tree are zero.
- Arithmetic: unsigned 64-bit, wraps modulo 2^64. No saturation.
- Invariants, holding on every output sample after reset: total_frame_errors <= total_frames; total_bit_errors_post <= total_bits; total_bit_errors_pre <= total_bits.
- Outputs are monotonically non-decreasing between resets.
- Reset mid-run: the next cycle all outputs read 0. Cores restart from their seeds, so the run is repeatable.

Optional Feature:
PRECODE_PORT_EN
- Defined: adds input port precode_en (1 bit). It is registered and broadcast to all cores to select precoded transmission.
- Undefined: no port exists and every core's precode_en is tied to 1.

Decomposition:
- Package parallel_sys7_pkg:
  - STAT_W=64, PROB_W=64, TABLE_DEPTH=64, IDX_W=32, IDX_IDLE=32'hFFFF_FFFF, SEED_STEP=32'h9E37_79B9.
  - Typedef stats_t: a struct of the five 64-bit counters.
- Sub-module stats_adder_tree: parameterised registered reduction of N stats_t inputs to one stats_t. It is instantiated once.
- sys7 is the existing core and is instantiated N_CORES times via generate, with parameter SEED.

Test Plan:
1. Load an all-zero table (idx 0..63), idx=FFFF_FFFF, then release rstn with en=1 -> total_bits and total_frames grow; all three error totals stay 0.
2. Load the 15 dB noise table, run 100k cycles -> total_bit_errors_pre > 0, total_bit_errors_post <= total_bit_errors_pre, total_frame_errors <= total_frames, all outputs non-decreasing.
3. With N_CORES=1, compare against a standalone sys7 with the same seed -> every output equals the core counter delayed by exactly L=1 cycles.
4. Drop en for 50 cycles mid-run -> outputs constant from 5 cycles after en falls until 5 cycles after en rises.
5. Assert rstn low for 1 cycle mid-run -> all outputs read 0 the next cycle. Rerun from identical config -> counts bit-identical to the first run at the same cycle offset.
6. Write idx=64 and idx=FFFF_FFFF with data 64'hFFFF_FFFF_FFFF_FFFF during a zero-table run -> no errors appear. n_interleave=0 gives results identical to n_interleave=1.

Source files
------------

// File: rtl/parallel_sys7_pkg.sv
// -----------------------------------------------------------------------------
// parallel_sys7_pkg
// Shared constants, the per-core statistics record and small helpers used by
// the parallel sys7 BER/FER measurement array.
//   stats_t    : the five 64-bit counters every core produces
//   stats_add  : field-wise modulo-2^64 sum of two stats_t records
//   xorshift64 : one step of the noise PRNG used by each core
// -----------------------------------------------------------------------------
package parallel_sys7_pkg;

   localparam int STAT_W      = 64;
   localparam int PROB_W      = 64;
   localparam int TABLE_DEPTH = 64;
   localparam int IDX_W       = 32;
   localparam int TBL_AW      = $clog2(TABLE_DEPTH);
   localparam int T_W         = 4;

   localparam logic [IDX_W-1:0] IDX_IDLE  = 32'hFFFF_FFFF;
   localparam logic [31:0]      SEED_STEP = 32'h9E37_79B9;

   typedef logic [STAT_W-1:0] stat_t;

   typedef struct packed {
      stat_t bits;
      stat_t bit_errors_pre;
      stat_t bit_errors_post;
      stat_t frames;
      stat_t frame_errors;
   } stats_t;

   // Unsigned adds; wrap modulo 2^64 by construction.
   function automatic stats_t stats_add(input stats_t a, input stats_t b);
      stats_t s;
      s.bits            = a.bits            + b.bits;
      s.bit_errors_pre  = a.bit_errors_pre  + b.bit_errors_pre;
      s.bit_errors_post = a.bit_errors_post + b.bit_errors_post;
      s.frames          = a.frames          + b.frames;
      s.frame_errors    = a.frame_errors    + b.frame_errors;
      return s;
   endfunction

   function automatic logic [63:0] xorshift64(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

endpackage

// File: rtl/parallel_sys7_stats_adder_tree.sv
// -----------------------------------------------------------------------------
// stats_adder_tree : registered binary reduction of N stats_t records.
// Nodes are stored heap-style: node 1 is the root, node k has children 2k and
// 2k+1, and nodes P..2P-1 are the leaves (P = next power of two >= N). Every
// node is a register, so latency is clog2(N) + 1 cycles. Leaves beyond N
// are tied to zero.
// Ports:
//   clk, rstn   clock, synchronous active-low reset clearing every node
//   stats_in    N per-core records
//   stats_out   registered grand total
// -----------------------------------------------------------------------------
module stats_adder_tree
   import parallel_sys7_pkg::*;
#(
   parameter int N = 10
) (
   input  logic   clk,
   input  logic   rstn,
   input  stats_t stats_in [N],
   output stats_t stats_out
);

   localparam int D = (N > 1) ? $clog2(N) : 0;
   localparam int P = 1 << D;

   stats_t leaf   [P];
   stats_t node_d [1:2*P-1];
   stats_t node_q [1:2*P-1];

   for (genvar j = 0; j < P; j++) begin : g_leaf
      if (j < N) begin : g_used
         assign leaf[j] = stats_in[j];
      end else begin : g_pad
         assign leaf[j] = '0;
      end
   end

   always_comb begin
      for (int k = 1; k < P; k++) node_d[k] = stats_add(node_q[2*k], node_q[2*k+1]);
      for (int k = 0; k < P; k++) node_d[P+k] = leaf[k];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 1; k < 2*P; k++) node_q[k] <= '0;
      end else begin
         node_q <= node_d;
      end
   end

   assign stats_out = node_q[1];

endmodule

// File: rtl/sys7.sv
// -----------------------------------------------------------------------------
// sys7 : one link-simulation core (transmit, noise injection, decode, count).
// One coded bit is transmitted per enabled cycle; a frame is TABLE_DEPTH bits
// and the probability table is indexed by bit position within the frame.
// A channel error occurs when the PRNG word is below the table entry. With
// precoding, the decoded error is the XOR of this and the previous channel
// error (differential decoding). A frame is uncorrectable when its decoded
// error count exceeds t_corr; then all its errors count as post-FEC errors.
// Ports:
//   clk, rstn          clock, synchronous active-low reset (table not reset)
//   en                 run enable; low freezes the core
//   tbl_we/addr/data   probability table write port
//   t_corr             correctable errors per frame (already clamped >= 1)
//   precode_en         select precoded transmission
//   stats_o            the five running counters
// -----------------------------------------------------------------------------
module sys7
   import parallel_sys7_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              tbl_we,
   input  logic [TBL_AW-1:0] tbl_addr,
   input  logic [PROB_W-1:0] tbl_data,
   input  logic [T_W-1:0]    t_corr,
   input  logic              precode_en,
   output stats_t            stats_o
);

   localparam int FE_W = TBL_AW + 1;
   localparam logic [TBL_AW-1:0] LAST_POS = TBL_AW'(TABLE_DEPTH - 1);

   // NOTE: the table has no reset branch so software can load it while rstn
   // is held low; clearing it would also force a flop-per-bit implementation.
   logic [PROB_W-1:0] prob_mem [TABLE_DEPTH];

   always_ff @(posedge clk) begin
      if (tbl_we) prob_mem[tbl_addr] <= tbl_data;
   end

   logic [63:0]       rng_d, rng_q;
   logic [TBL_AW-1:0] bit_pos_d, bit_pos_q;
   logic              prev_err_d, prev_err_q;
   logic [FE_W-1:0]   frame_err_d, frame_err_q;
   stats_t            stats_d, stats_q;

   logic              ch_err;
   logic              dec_err;
   logic [FE_W-1:0]   frame_total;

   always_comb begin
      // NOTE: every signal gets a default before any branch so the block
      // stays purely combinational (no latch when en is low).
      rng_d       = rng_q;
      bit_pos_d   = bit_pos_q;
      prev_err_d  = prev_err_q;
      frame_err_d = frame_err_q;
      stats_d     = stats_q;

      ch_err      = rng_q < prob_mem[bit_pos_q];
      dec_err     = precode_en ? (ch_err ^ prev_err_q) : ch_err;
      frame_total = frame_err_q + FE_W'(dec_err);

      if (en) begin
         rng_d                  = xorshift64(rng_q);
         bit_pos_d              = bit_pos_q + TBL_AW'(1);
         prev_err_d             = ch_err;
         stats_d.bits           = stats_q.bits + 64'd1;
         stats_d.bit_errors_pre = stats_q.bit_errors_pre + 64'(dec_err);
         if (bit_pos_q == LAST_POS) begin
            frame_err_d    = '0;
            stats_d.frames = stats_q.frames + 64'd1;
            if (frame_total > FE_W'(t_corr)) begin
               stats_d.frame_errors    = stats_q.frame_errors + 64'd1;
               stats_d.bit_errors_post = stats_q.bit_errors_post + 64'(frame_total);
            end
         end else begin
            frame_err_d = frame_total;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (!rstn) begin
         rng_q       <= {SEED, ~SEED};  // never all-zero, a dead xorshift state
         bit_pos_q   <= '0;
         prev_err_q  <= 1'b0;
         frame_err_q <= '0;
         stats_q     <= '0;
      end else begin
         rng_q       <= rng_d;
         bit_pos_q   <= bit_pos_d;
         prev_err_q  <= prev_err_d;
         frame_err_q <= frame_err_d;
         stats_q     <= stats_d;
      end
   end

   assign stats_o = stats_q;

endmodule

// File: rtl/parallel_sys7.sv
// -----------------------------------------------------------------------------
// parallel_sys7 : array of N_CORES sys7 cores sharing one probability table
// and configuration, with a registered adder tree summing their statistics.
// Core i is seeded with SEED_BASE + i*SEED_STEP.
// Optional feature macro: PRECODE_PORT_EN adds input precode_en (registered
// and broadcast); without it every core runs precoded.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   en                   run enable, forwarded unregistered to the cores
//   probability_in/idx   table write data/address; idx >= 64 is idle
//   n_interleave         FEC interleave depth (0 treated as 1)
//   total_*              sums of the per-core counters, latency clog2(N)+1
// -----------------------------------------------------------------------------
module parallel_sys7
   import parallel_sys7_pkg::*;
#(
   parameter int          N_CORES   = 10,
   parameter logic [31:0] SEED_BASE = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic [PROB_W-1:0] probability_in,
   input  logic [IDX_W-1:0]  probability_idx,
   input  logic [T_W-1:0]    n_interleave,
`ifdef PRECODE_PORT_EN
   input  logic              precode_en,
`endif
   output logic [STAT_W-1:0] total_bits,
   output logic [STAT_W-1:0] total_bit_errors_pre,
   output logic [STAT_W-1:0] total_bit_errors_post,
   output logic [STAT_W-1:0] total_frames,
   output logic [STAT_W-1:0] total_frame_errors
);

   // Table-write broadcast registers are free-running (no reset) so that
   // writes issued while rstn is low still reach the cores.
   logic [IDX_W-1:0]  wr_idx_d, wr_idx_q;
   logic [PROB_W-1:0] wr_data_d, wr_data_q;
   logic [T_W-1:0]    n_int_d, n_int_q;

   logic              tbl_we;
   logic [T_W-1:0]    t_corr;
   logic              precode_bc;

   always_comb begin
      wr_idx_d  = probability_idx;
      wr_data_d = probability_in;
      n_int_d   = n_interleave;
   end

   always_ff @(posedge clk) begin
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) n_int_q <= '0;
      else       n_int_q <= n_int_d;
   end

`ifdef PRECODE_PORT_EN
   logic precode_d, precode_q;

   always_comb precode_d = precode_en;

   always_ff @(posedge clk) begin
      if (!rstn) precode_q <= 1'b0;
      else       precode_q <= precode_d;
   end

   assign precode_bc = precode_q;
`else
   assign precode_bc = 1'b1;
`endif

   assign tbl_we = (wr_idx_q != IDX_IDLE) && (wr_idx_q < IDX_W'(TABLE_DEPTH));
   assign t_corr = (n_int_q == '0) ? T_W'(1) : n_int_q;

   stats_t core_stats [N_CORES];
   stats_t grand;

   for (genvar i = 0; i < N_CORES; i++) begin : g_core
      localparam logic [31:0] CORE_SEED = SEED_BASE + 32'(i) * SEED_STEP;
      sys7 #(.SEED(CORE_SEED)) u_core (
         .clk        (clk),
         .rstn       (rstn),
         .en         (en),
         .tbl_we     (tbl_we),
         .tbl_addr   (wr_idx_q[TBL_AW-1:0]),
         .tbl_data   (wr_data_q),
         .t_corr     (t_corr),
         .precode_en (precode_bc),
         .stats_o    (core_stats[i])
      );
   end

   stats_adder_tree #(.N(N_CORES)) u_tree (
      .clk       (clk),
      .rstn      (rstn),
      .stats_in  (core_stats),
      .stats_out (grand)
   );

   assign total_bits            = grand.bits;
   assign total_bit_errors_pre  = grand.bit_errors_pre;
   assign total_bit_errors_post = grand.bit_errors_post;
   assign total_frames          = grand.frames;
   assign total_frame_errors    = grand.frame_errors;

endmodule

// File: tb/tb_parallel_sys7.sv
// -----------------------------------------------------------------------------
// tb_parallel_sys7 : bench for parallel_sys7 (10-core and 1-core instances).
// With a zero table every enabled cycle adds one bit per core and a frame
// every 64 bits, with no errors; the model keeps the enabled-cycle count per
// edge and predicts each output as that count L edges earlier (zero if a
// reset occurred since). With a noisy table the model checks the ordering
// invariants and monotonicity, and directed runs check repeatability and the
// n_interleave clamp.
// -----------------------------------------------------------------------------
module tb_parallel_sys7;
   import parallel_sys7_pkg::*;

   localparam int N_BIG = 10;
   localparam int L_BIG = 5;
   localparam int N_ONE = 1;
   localparam int L_ONE = 1;
   localparam int FRAME = 64;
   localparam int MAXC  = 20000;
   localparam int K_RUN = 3000;
   localparam logic [63:0] P_NOISE = 64'h0200_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic [63:0] prob_in = '0;
   logic [31:0] prob_idx = IDX_IDLE;
   logic [3:0]  n_int = 4'd1;

   logic [63:0] a_bits, a_pre, a_post, a_frames, a_ferr;
   logic [63:0] b_bits, b_pre, b_post, b_frames, b_ferr;

   always #5 clk = ~clk;

   parallel_sys7 #(.N_CORES(N_BIG)) dut_big (
      .clk(clk), .rstn(rstn), .en(en),
      .probability_in(prob_in), .probability_idx(prob_idx), .n_interleave(n_int),
      .total_bits(a_bits), .total_bit_errors_pre(a_pre), .total_bit_errors_post(a_post),
      .total_frames(a_frames), .total_frame_errors(a_ferr)
   );

   parallel_sys7 #(.N_CORES(N_ONE)) dut_one (
      .clk(clk), .rstn(rstn), .en(en),
      .probability_in(prob_in), .probability_idx(prob_idx), .n_interleave(n_int),
      .total_bits(b_bits), .total_bit_errors_pre(b_pre), .total_bit_errors_post(b_post),
      .total_frames(b_frames), .total_frame_errors(b_ferr)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Requires lo <= hi.
   task automatic check_le(input string name, input logic [63:0] lo, input logic [63:0] hi);
      total++;
      if (!(lo <= hi)) begin
         bad++;
         $display("FAIL %s: %0d is not <= %0d", name, lo, hi);
      end
   endtask

   // ---------------- model: enabled-cycle count per edge ----------------
   int     cyc = -1;
   int     rst_edge = 0;
   longint cnt = 0;
   longint cnt_hist [MAXC];
   bit     armed = 1'b0;
   bit     exact_mode = 1'b1;
   bit     last_edge_rst = 1'b0;

   always @(posedge clk) begin
      cyc++;
      last_edge_rst = !rstn;
      if (!rstn) begin
         cnt      = 0;
         rst_edge = cyc;
         armed    = 1'b1;
      end else if (en) begin
         cnt++;
      end
      if (cyc < MAXC) cnt_hist[cyc] = cnt;
   end

   function automatic longint delayed(input int lat);
      if (cyc - lat < rst_edge) return 0;
      return cnt_hist[cyc - lat];
   endfunction

   // ---------------- compare process ----------------
   longint      ca, cb;
   logic [63:0] pa [5];
   logic [63:0] pb [5];
   bit          have_prev = 1'b0;

   always @(negedge clk) begin
      if (armed) begin
         if (exact_mode) begin
            ca = delayed(L_BIG);
            cb = delayed(L_ONE);
            check("big.bits",   a_bits,   64'(N_BIG * ca));
            check("big.frames", a_frames, 64'(N_BIG * (ca / FRAME)));
            check("big.pre",    a_pre,    64'd0);
            check("big.post",   a_post,   64'd0);
            check("big.ferr",   a_ferr,   64'd0);
            check("one.bits",   b_bits,   64'(N_ONE * cb));
            check("one.frames", b_frames, 64'(N_ONE * (cb / FRAME)));
            check("one.pre",    b_pre,    64'd0);
            check("one.post",   b_post,   64'd0);
            check("one.ferr",   b_ferr,   64'd0);
         end
         check_le("big.ferr<=frames", a_ferr, a_frames);
         check_le("big.post<=bits",   a_post, a_bits);
         check_le("big.pre<=bits",    a_pre,  a_bits);
         check_le("one.ferr<=frames", b_ferr, b_frames);
         check_le("one.post<=bits",   b_post, b_bits);
         check_le("one.pre<=bits",    b_pre,  b_bits);
         if (have_prev && !last_edge_rst) begin
            check_le("big.mono.bits",   pa[0], a_bits);
            check_le("big.mono.pre",    pa[1], a_pre);
            check_le("big.mono.post",   pa[2], a_post);
            check_le("big.mono.frames", pa[3], a_frames);
            check_le("big.mono.ferr",   pa[4], a_ferr);
            check_le("one.mono.bits",   pb[0], b_bits);
            check_le("one.mono.pre",    pb[1], b_pre);
            check_le("one.mono.post",   pb[2], b_post);
            check_le("one.mono.frames", pb[3], b_frames);
            check_le("one.mono.ferr",   pb[4], b_ferr);
         end
         pa[0] = a_bits; pa[1] = a_pre; pa[2] = a_post; pa[3] = a_frames; pa[4] = a_ferr;
         pb[0] = b_bits; pb[1] = b_pre; pb[2] = b_post; pb[3] = b_frames; pb[4] = b_ferr;
         have_prev = 1'b1;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_table(input logic [63:0] value);
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         prob_idx = 32'(i);
         prob_in  = value;
         tick(1);
      end
      prob_idx = IDX_IDLE;
      prob_in  = '0;
      tick(2);
   endtask

   logic [63:0] ref_bits, ref_pre, ref_post, ref_frames, ref_ferr;

   initial begin
      // Zero table loaded while held in reset.
      tick(2);
      load_table(64'd0);
      check("rst.big.bits",   a_bits,   64'd0);
      check("rst.big.frames", a_frames, 64'd0);
      check("rst.big.pre",    a_pre,    64'd0);
      check("rst.one.bits",   b_bits,   64'd0);
      check("rst.one.frames", b_frames, 64'd0);

      // Release: 133 enabled edges -> big sees 128 per core, one sees 132.
      rstn = 1'b1;
      en   = 1'b1;
      tick(133);
      check("run.big.bits",   a_bits,   64'd1280);
      check("run.big.frames", a_frames, 64'd20);
      check("run.one.bits",   b_bits,   64'd132);
      check("run.one.frames", b_frames, 64'd2);

      // en low for 50 cycles: totals freeze at 133 per core.
      en = 1'b0;
      tick(50);
      check("stall.big.bits", a_bits, 64'd1330);
      en = 1'b1;
      tick(3);
      check("stall.tail.big.bits", a_bits, 64'd1330);
      tick(7);
      check("resume.big.bits", a_bits, 64'd1380);
      check("resume.one.bits", b_bits, 64'd142);

      // Out-of-range writes of all-ones must not touch the table.
      prob_in  = '1;
      prob_idx = 32'd64;
      tick(1);
      prob_idx = IDX_IDLE;
      tick(1);
      prob_idx = 32'h8000_0000;
      tick(1);
      prob_idx = IDX_IDLE;
      prob_in  = '0;
      tick(99);
      check("oor.big.bits",   a_bits,   64'd2400);
      check("oor.big.frames", a_frames, 64'd30);
      check("oor.big.pre",    a_pre,    64'd0);
      check("oor.big.post",   a_post,   64'd0);
      check("oor.big.ferr",   a_ferr,   64'd0);

      // One-cycle reset mid-run.
      rstn = 1'b0;
      tick(1);
      check("midrst.big.bits",   a_bits,   64'd0);
      check("midrst.big.frames", a_frames, 64'd0);
      check("midrst.one.bits",   b_bits,   64'd0);
      rstn = 1'b1;
      tick(70);
      check("rerun.big.bits",   a_bits,   64'd650);
      check("rerun.big.frames", a_frames, 64'd10);
      check("rerun.one.bits",   b_bits,   64'd69);
      check("rerun.one.frames", b_frames, 64'd1);

      // Noisy table: only invariants are modelled from here on.
      exact_mode = 1'b0;
      rstn = 1'b0;
      en   = 1'b0;
      tick(1);
      load_table(P_NOISE);
      rstn = 1'b1;
      en   = 1'b1;
      tick(K_RUN);
      ref_bits = a_bits; ref_pre = a_pre; ref_post = a_post;
      ref_frames = a_frames; ref_ferr = a_ferr;
      check("noise.big.bits", a_bits, 64'(N_BIG * (K_RUN - L_BIG)));
      check_le("noise.big.pre>0", 64'd1, a_pre);
      check_le("noise.one.pre>0", 64'd1, b_pre);
      check_le("noise.big.post<=pre", a_post, a_pre);
      check_le("noise.one.post<=pre", b_post, b_pre);

      // Repeat from identical configuration.
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      tick(K_RUN);
      check("repeat.bits",   a_bits,   ref_bits);
      check("repeat.pre",    a_pre,    ref_pre);
      check("repeat.post",   a_post,   ref_post);
      check("repeat.frames", a_frames, ref_frames);
      check("repeat.ferr",   a_ferr,   ref_ferr);

      // n_interleave = 0 behaves as 1.
      rstn  = 1'b0;
      n_int = 4'd0;
      tick(1);
      rstn = 1'b1;
      tick(K_RUN);
      check("nint0.bits",   a_bits,   ref_bits);
      check("nint0.pre",    a_pre,    ref_pre);
      check("nint0.post",   a_post,   ref_post);
      check("nint0.frames", a_frames, ref_frames);
      check("nint0.ferr",   a_ferr,   ref_ferr);

      // Deeper interleave corrects more: fewer uncorrectable frames.
      rstn  = 1'b0;
      n_int = 4'd15;
      tick(1);
      rstn = 1'b1;
      tick(K_RUN);
      check("nint15.bits", a_bits, ref_bits);
      check("nint15.pre",  a_pre,  ref_pre);
      check_le("nint15.post<=nint1", a_post, ref_post);
      check_le("nint15.ferr<nint1", a_ferr + 64'd1, ref_ferr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
